aes_block_loader: RTL

//   Byte-serial input stage feeding the AES encrypt/decrypt core. Accepts key and

---
 rtl/aes_block_loader.sv | 115 +++++++++++
 1 files changed

// File: rtl/aes_block_loader.sv
// Byte-serial key/data assembler that feeds the AES core.
// Key bytes are stored MSB-justified, data bytes go first-byte-high, and each finished block is held until the core accepts it.
module aes_block_loader #(
   parameter int unsigned DATA_BYTES = 16,
   parameter int unsigned KEY_BYTES  = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              sel,
   input  logic                    reload_key,
   input  logic                    in_valid,
   input  logic [7:0]              in_byte,
   output logic                    in_ready,
   output logic [8*KEY_BYTES-1:0]  key_out,
   output logic [8*DATA_BYTES-1:0] data_out,
   output logic [1:0]              sel_out,
   output logic                    block_valid,
   input  logic                    block_ready,
   output logic                    err_nokey
);

   localparam int unsigned KW  = 8 * KEY_BYTES;
   localparam int unsigned DW  = 8 * DATA_BYTES;
   localparam int unsigned KIW = $clog2(KW);
   localparam int unsigned DIW = $clog2(DW);

   typedef enum logic [1:0] {IDLE, LOAD_KEY, LOAD_DATA, HOLD} state_t;

   state_t         state;
   logic [5:0]     cnt;
   logic           key_loaded;
   logic [5:0]     key_last;
   logic [KIW-1:0] key_idx;
   logic [DIW-1:0] data_idx;
   logic           accept;

   always_comb begin
      in_ready = reset && (state != HOLD);
      accept   = in_valid && in_ready;
      case (sel_out)
         2'b00:   key_last = 6'd15;
         2'b01:   key_last = 6'd23;
         default: key_last = 6'(KEY_BYTES - 1);
      endcase
      // Top bit of the byte lane addressed by cnt, counting down from the MSB.
      key_idx  = KIW'(KW - 1) - KIW'({cnt, 3'b000});
      data_idx = DIW'(DW - 1) - DIW'({cnt, 3'b000});
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         key_loaded  <= 1'b0;
         key_out     <= '0;
         data_out    <= '0;
         sel_out     <= '0;
         block_valid <= 1'b0;
         err_nokey   <= 1'b0;
      end else begin
         err_nokey <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  sel_out <= sel;
                  if (reload_key) begin
                     key_out <= {in_byte, {(KW-8){1'b0}}};
                     cnt     <= 6'd1;
                     state   <= LOAD_KEY;
                  end else if (key_loaded) begin
                     data_out[DW-1 -: 8] <= in_byte;
                     cnt                 <= 6'd1;
                     state               <= LOAD_DATA;
                  end else begin
                     err_nokey <= 1'b1;
                  end
               end
            end
            LOAD_KEY: begin
               if (accept) begin
                  key_out[key_idx -: 8] <= in_byte;
                  if (cnt == key_last) begin
                     key_loaded <= 1'b1;
                     cnt        <= '0;
                     state      <= LOAD_DATA;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end
            end
            LOAD_DATA: begin
               if (accept) begin
                  data_out[data_idx -: 8] <= in_byte;
                  if (cnt == 6'(DATA_BYTES - 1)) begin
                     cnt         <= '0;
                     block_valid <= 1'b1;
                     state       <= HOLD;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end
            end
            HOLD: begin
               if (block_valid && block_ready) begin
                  block_valid <= 1'b0;
                  cnt         <= '0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
